div_clk_checker: RTL and testbench
==================================

Name: div_clk_checker

Overview:
- Downstream consumer of the synchronous mod-N divider output (clk_out); runs on the same master clock.
- Detects rising and falling edges of the divided clock and emits a one-cycle clock-enable pulse per divided period.
- Measures each period and high time, asserts a lock indication after consecutive correct periods, and raises sticky period/duty error flags.

Parameters:
- N, 4, expected divide ratio (master cycles per divided period), >=2
- HIGH_CYC, N/2 (integer floor), expected master cycles divided clock is high per period
- LOCK_CNT, 3, consecutive good periods required to assert locked
- CNT_W, 8, width of measurement counters; must satisfy 2^CNT_W-1 >= 2*N

Ports:
- clk  in  1  master clock (same clock driving the divider)
- rst  in  1  asynchronous active-high reset
- en  in  1  checker enable
- div_in  in  1  divided clock from divider, registered in clk domain
- err_clr  in  1  synchronous clear of sticky error flags
- rise_pulse  out  1  high for exactly one clk cycle per div_in rising edge
- locked  out  1  divider verified running at ratio N
- err_period  out  1  sticky: bad period or stuck divided clock
- err_duty  out  1  sticky: high time != HIGH_CYC
- period_last  out  CNT_W  last measured period in clk cycles

Behaviour:
- Reset (async, rst=1): div_q=0, all counters 0, state IDLE; outputs locked=0, err_period=0, err_duty=0, period_last=0, rise_pulse=0.
- Edge detection:
  - div_q = div_in delayed one clk.
  - rise = div_in & ~div_q; fall = ~div_in & div_q.
  - rise_pulse = rise & en, combinational, 0 cycles latency from div_in.
- per_cnt:
  - Loads 1 on rise; otherwise increments each cycle.
  - Saturates at 2^CNT_W-1.
- hi_cnt:
  - Loads 1 on rise; increments while div_in=1; holds while div_in=0.
- FSM states: IDLE, ACQUIRE, MEASURE, LOCKED.
  - IDLE: en=1 -> ACQUIRE.
  - ACQUIRE: first rise -> MEASURE (no period captured; counters start); good_cnt=0.
  - MEASURE:
    - On rise: period_last <= per_cnt.
    - per_cnt==N -> good_cnt+1. Else err_period set, good_cnt=0, stay MEASURE.
    - good_cnt reaching LOCK_CNT -> LOCKED.
  - LOCKED: locked=1 (registered; asserts the cycle after entry). Any period error, duty error or timeout -> ACQUIRE, locked=0 next cycle, good_cnt=0.
  - Any state: en=0 -> IDLE next cycle; counters cleared, locked=0, sticky flags held.
- Duty check (MEASURE/LOCKED):
  - On fall, hi_cnt != HIGH_CYC -> err_duty set.
  - In MEASURE this also zeroes good_cnt.
- Timeout (MEASURE/LOCKED): per_cnt == 2*N with no rise that cycle -> err_period set, state -> ACQUIRE.
- Sticky flags:
  - Cleared by err_clr.
  - A new error in the same cycle as err_clr wins (flag stays 1).
- Rise and timeout in the same cycle: the rise is evaluated, no timeout.
- Reset mid-operation: immediate return to reset values regardless of state.

Decomposition:
- Package div_clk_checker_pkg holds:
  - state enum (IDLE, ACQUIRE, MEASURE, LOCKED);
  - a function computing the timeout limit 2*N;
  - default LOCK_CNT.
- One sub-module, div_edge_det: div_q register plus rise/fall outputs, with clk/rst. Reusable by other divider stages.
- Counters and FSM stay in the top module.

Test Plan (N=4, HIGH_CYC=2, LOCK_CNT=3):
- Reset, then en=1, div_in pattern 1100 repeating, rises at cycles t0, t0+4, t0+8, t0+12 -> rise_pulse at each rise; period_last=4 from t0+5; locked=1 at t0+13; both errors 0.
- After lock, one period of pattern 11000 (5 cycles) -> err_period=1, period_last=5, locked=0 next cycle; resume 1100 -> locked again 3 good periods later; err_period remains 1.
- After lock, pattern 1110 -> err_duty=1 at fall (hi_cnt=3), locked drops; err_clr pulse alone -> err_duty=0 next cycle.
- After lock, div_in held 0 -> err_period=1 when per_cnt reaches 8 (8 cycles after last rise), state ACQUIRE, locked=0.
- err_clr asserted in the same cycle as a new period error -> err_period stays 1.
- rst pulsed mid-lock asynchronously (between clock edges) -> all outputs 0 immediately.
- en deasserted mid-lock -> IDLE next cycle, locked=0, rise_pulse suppressed, sticky flags retained.

Source files
------------

// File: rtl/div_clk_checker_pkg.sv
// Shared types and constants for the divided-clock checker.
//   state_e         : checker FSM states
//   DEFAULT_LOCK_CNT: default number of consecutive good periods before lock
//   timeout_limit() : per_cnt value at which a missing rise is declared (2*N)
package div_clk_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_MEASURE = 2'd2,
    ST_LOCKED  = 2'd3
  } state_e;

  localparam int DEFAULT_LOCK_CNT = 3;

  function automatic int timeout_limit(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/div_edge_det.sv
// Edge detector for a signal already registered in the clk domain.
// Keeps a one-cycle delayed copy and flags rising/falling transitions
// combinationally in the same cycle the input changes.
//   clk    : master clock
//   rst    : asynchronous active-high reset (delayed copy cleared to 0)
//   sig_i  : input signal (e.g. divided clock)
//   rise_o : sig_i & ~sig_q
//   fall_o : ~sig_i & sig_q
module div_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/div_clk_checker.sv
// Checker for a synchronous mod-N divided clock sampled on the master clock.
// Produces a clock-enable pulse per divided rising edge, measures period and
// high time, declares lock after LOCK_CNT consecutive good periods and keeps
// sticky period/duty error flags.
//   clk         : master clock
//   rst         : asynchronous active-high reset
//   en          : checker enable (0 forces IDLE, sticky flags held)
//   div_in      : divided clock, registered in clk domain
//   err_clr     : synchronous clear of sticky flags (a same-cycle error wins)
//   rise_pulse  : one-cycle pulse on each div_in rising edge while enabled
//   locked      : divider verified running at ratio N
//   err_period  : sticky, wrong period or divided clock stuck
//   err_duty    : sticky, high time differs from HIGH_CYC
//   period_last : most recently measured period in clk cycles
module div_clk_checker
  import div_clk_checker_pkg::*;
#(
  parameter int N        = 4,
  parameter int HIGH_CYC = N / 2,
  parameter int LOCK_CNT = DEFAULT_LOCK_CNT,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_in,
  input  logic             err_clr,
  output logic             rise_pulse,
  output logic             locked,
  output logic             err_period,
  output logic             err_duty,
  output logic [CNT_W-1:0] period_last
);

  localparam logic [CNT_W-1:0] N_C    = CNT_W'(N);
  localparam logic [CNT_W-1:0] HI_C   = CNT_W'(HIGH_CYC);
  localparam logic [CNT_W-1:0] LOCK_C = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] TO_C   = CNT_W'(timeout_limit(N));
  localparam logic [CNT_W-1:0] MAX_C  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  logic rise;
  logic fall;

  state_e           state_q;
  logic [CNT_W-1:0] per_cnt_q;
  logic [CNT_W-1:0] per_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q;
  logic [CNT_W-1:0] hi_cnt_d;
  logic [CNT_W-1:0] good_cnt_q;
  logic [CNT_W-1:0] period_last_q;
  logic             locked_q;
  logic             err_period_q;
  logic             err_duty_q;

  logic per_good;
  logic duty_bad;
  logic timeout;
  logic lock_fault;

  div_edge_det u_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (div_in),
    .rise_o (rise),
    .fall_o (fall)
  );

  // Gated by rst so the pulse stays low while reset is held even if div_in is high.
  assign rise_pulse = rise & en & ~rst;

  assign per_good = (per_cnt_q == N_C);
  assign duty_bad = (hi_cnt_q != HI_C);
  // A rise in the same cycle takes priority over the timeout.
  assign timeout  = (per_cnt_q == TO_C) && !rise;
  assign lock_fault = (rise && !per_good) || timeout || (fall && duty_bad);

  // Measurement counters: both restart at 1 on a rise so that on the next rise
  // per_cnt equals the period and on the next fall hi_cnt equals the high time.
  always_comb begin
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    if (!en || state_q == ST_IDLE) begin
      per_cnt_d = '0;
      hi_cnt_d  = '0;
    end else if (rise) begin
      per_cnt_d = ONE_C;
      hi_cnt_d  = ONE_C;
    end else begin
      if (per_cnt_q != MAX_C) begin
        per_cnt_d = per_cnt_q + ONE_C;
      end
      if (div_in && hi_cnt_q != MAX_C) begin
        hi_cnt_d = hi_cnt_q + ONE_C;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
    end else begin
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
    end
  end

  // FSM with registered outputs. Clear of the sticky flags is written first so
  // any error raised later in the same cycle overrides it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      good_cnt_q    <= '0;
      period_last_q <= '0;
      locked_q      <= 1'b0;
      err_period_q  <= 1'b0;
      err_duty_q    <= 1'b0;
    end else begin
      if (err_clr) begin
        err_period_q <= 1'b0;
        err_duty_q   <= 1'b0;
      end
      if (!en) begin
        state_q    <= ST_IDLE;
        good_cnt_q <= '0;
        locked_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_ACQUIRE;
          end
          ST_ACQUIRE: begin
            good_cnt_q <= '0;
            // First rise only aligns the counters; no period is captured.
            if (rise) begin
              state_q <= ST_MEASURE;
            end
          end
          ST_MEASURE: begin
            if (rise) begin
              period_last_q <= per_cnt_q;
              if (per_good) begin
                good_cnt_q <= good_cnt_q + ONE_C;
                if ((good_cnt_q + ONE_C) >= LOCK_C) begin
                  state_q  <= ST_LOCKED;
                  locked_q <= 1'b1;
                end
              end else begin
                err_period_q <= 1'b1;
                good_cnt_q   <= '0;
              end
            end else if (timeout) begin
              err_period_q <= 1'b1;
              good_cnt_q   <= '0;
              state_q      <= ST_ACQUIRE;
            end
            if (fall && duty_bad) begin
              err_duty_q <= 1'b1;
              good_cnt_q <= '0;
            end
          end
          ST_LOCKED: begin
            if (rise) begin
              period_last_q <= per_cnt_q;
            end
            if ((rise && !per_good) || timeout) begin
              err_period_q <= 1'b1;
            end
            if (fall && duty_bad) begin
              err_duty_q <= 1'b1;
            end
            if (lock_fault) begin
              state_q    <= ST_ACQUIRE;
              locked_q   <= 1'b0;
              good_cnt_q <= '0;
            end
          end
          default: begin
            state_q  <= ST_IDLE;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked      = locked_q;
  assign err_period  = err_period_q;
  assign err_duty    = err_duty_q;
  assign period_last = period_last_q;

endmodule

// File: tb/tb_div_clk_checker.sv
// Directed bench for div_clk_checker with N=4, HIGH_CYC=2, LOCK_CNT=3.
// Inputs change 1 time unit after a rising clk edge; outputs are sampled on
// the following falling edge, so registered outputs seen in a cycle reflect
// the inputs of the previous cycle.
module tb_div_clk_checker;

  logic       clk;
  logic       rst;
  logic       en;
  logic       div_in;
  logic       err_clr;
  logic       rise_pulse;
  logic       locked;
  logic       err_period;
  logic       err_duty;
  logic [7:0] period_last;

  logic en_nx;
  logic clr_nx;
  int   n_cmp;
  int   n_bad;

  div_clk_checker #(
    .N        (4),
    .HIGH_CYC (2),
    .LOCK_CNT (3),
    .CNT_W    (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .div_in      (div_in),
    .err_clr     (err_clr),
    .rise_pulse  (rise_pulse),
    .locked      (locked),
    .err_period  (err_period),
    .err_duty    (err_duty),
    .period_last (period_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One master cycle: apply inputs after the edge, return at the falling edge.
  task automatic cyc(input logic d);
    @(posedge clk);
    #1;
    div_in  = d;
    en      = en_nx;
    err_clr = clr_nx;
    @(negedge clk);
  endtask

  // One divided period starting with a rise: hi cycles high, len total.
  task automatic period(input int hi, input int len);
    for (int i = 0; i < len; i++) begin
      cyc(i < hi);
      chk("rise_pulse_period", {31'd0, rise_pulse}, (i == 0) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    en      = 1'b0;
    div_in  = 1'b0;
    err_clr = 1'b0;
    en_nx   = 1'b0;
    clr_nx  = 1'b0;

    // Reset state
    #2;
    chk("reset_locked", {31'd0, locked}, 32'd0);
    chk("reset_err_period", {31'd0, err_period}, 32'd0);
    chk("reset_err_duty", {31'd0, err_duty}, 32'd0);
    chk("reset_period_last", {24'd0, period_last}, 32'd0);
    chk("reset_rise_pulse", {31'd0, rise_pulse}, 32'd0);
    #10;
    rst = 1'b0;
    cyc(1'b0);
    cyc(1'b0);

    // Acquire and lock on 1100 pattern
    en_nx = 1'b1;
    cyc(1'b0);                       // IDLE -> ACQUIRE
    period(2, 4);                    // t0: first rise, no capture
    chk("acq_no_capture", {24'd0, period_last}, 32'd0);
    period(2, 4);                    // t0+4
    period(2, 4);                    // t0+8
    chk("period_last_4", {24'd0, period_last}, 32'd4);
    chk("pre_lock_locked", {31'd0, locked}, 32'd0);
    chk("pre_lock_err_period", {31'd0, err_period}, 32'd0);
    chk("pre_lock_err_duty", {31'd0, err_duty}, 32'd0);
    cyc(1'b1);                       // t0+12: third good period
    chk("lock_t0_12", {31'd0, locked}, 32'd0);
    cyc(1'b1);                       // t0+13
    chk("lock_t0_13", {31'd0, locked}, 32'd1);
    cyc(1'b0);
    cyc(1'b0);

    // One 5-cycle period while locked
    period(2, 5);                    // r .. r+4
    cyc(1'b1);                       // r+5: bad rise
    chk("long_locked_same", {31'd0, locked}, 32'd1);
    chk("long_err_same", {31'd0, err_period}, 32'd0);
    cyc(1'b1);                       // r+6
    chk("long_err_period", {31'd0, err_period}, 32'd1);
    chk("long_period_last", {24'd0, period_last}, 32'd5);
    chk("long_locked_drop", {31'd0, locked}, 32'd0);
    cyc(1'b0);
    cyc(1'b0);
    period(2, 4);                    // r+9 first rise in ACQUIRE
    period(2, 4);
    period(2, 4);
    cyc(1'b1);                       // r+21 third good
    chk("relock_before", {31'd0, locked}, 32'd0);
    cyc(1'b1);                       // r+22
    chk("relock_locked", {31'd0, locked}, 32'd1);
    chk("relock_err_sticky", {31'd0, err_period}, 32'd1);
    cyc(1'b0);
    cyc(1'b0);

    // Duty error: 1110 while locked
    period(3, 4);                    // s .. s+3, fall at s+3 with hi_cnt=3
    chk("duty_same_cycle", {31'd0, err_duty}, 32'd0);
    cyc(1'b1);                       // s+4
    chk("duty_err_set", {31'd0, err_duty}, 32'd1);
    chk("duty_locked_drop", {31'd0, locked}, 32'd0);
    clr_nx = 1'b1;
    cyc(1'b1);                       // s+5: clear applied
    chk("clr_pending", {31'd0, err_duty}, 32'd1);
    clr_nx = 1'b0;
    cyc(1'b0);                       // s+6
    chk("clr_err_duty", {31'd0, err_duty}, 32'd0);
    chk("clr_err_period", {31'd0, err_period}, 32'd0);
    cyc(1'b0);
    period(2, 4);                    // s+8
    period(2, 4);                    // s+12
    cyc(1'b1);                       // s+16
    cyc(1'b1);                       // s+17
    chk("duty_relock", {31'd0, locked}, 32'd1);
    cyc(1'b0);
    cyc(1'b0);

    // Stuck low: timeout at per_cnt == 8
    for (int i = 0; i < 5; i++) cyc(1'b0);   // s+20 .. s+24
    chk("timeout_before", {31'd0, err_period}, 32'd0);
    chk("timeout_locked_before", {31'd0, locked}, 32'd1);
    cyc(1'b0);                       // s+25
    chk("timeout_err_period", {31'd0, err_period}, 32'd1);
    chk("timeout_locked", {31'd0, locked}, 32'd0);

    // err_clr colliding with a new period error
    clr_nx = 1'b1;
    cyc(1'b0);
    clr_nx = 1'b0;
    cyc(1'b0);
    chk("clr_alone_period", {31'd0, err_period}, 32'd0);
    cyc(1'b1);                       // u: first rise
    cyc(1'b1);
    cyc(1'b0);
    clr_nx = 1'b1;
    cyc(1'b1);                       // u+3: 3-cycle period plus clear
    clr_nx = 1'b0;
    cyc(1'b1);                       // u+4
    chk("clr_vs_err_period", {31'd0, err_period}, 32'd1);
    chk("clr_vs_err_duty", {31'd0, err_duty}, 32'd0);
    chk("short_period_last", {24'd0, period_last}, 32'd3);
    cyc(1'b0);
    cyc(1'b0);
    period(2, 4);                    // u+7
    period(2, 4);                    // u+11
    cyc(1'b1);                       // u+15
    cyc(1'b1);                       // u+16
    chk("clr_relock", {31'd0, locked}, 32'd1);
    cyc(1'b0);
    cyc(1'b0);

    // Disable mid-lock
    en_nx = 1'b0;
    cyc(1'b1);                       // v: rise with en=0
    chk("dis_rise_pulse", {31'd0, rise_pulse}, 32'd0);
    chk("dis_locked_same", {31'd0, locked}, 32'd1);
    cyc(1'b1);                       // v+1
    chk("dis_locked", {31'd0, locked}, 32'd0);
    chk("dis_err_period_held", {31'd0, err_period}, 32'd1);
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b1);                       // v+4
    chk("dis_rise_pulse2", {31'd0, rise_pulse}, 32'd0);
    chk("dis_locked2", {31'd0, locked}, 32'd0);
    en_nx = 1'b1;
    cyc(1'b1);                       // v+5 IDLE -> ACQUIRE
    cyc(1'b0);
    cyc(1'b0);
    period(2, 4);                    // w
    period(2, 4);
    period(2, 4);
    cyc(1'b1);                       // w+12
    cyc(1'b1);                       // w+13
    chk("en_relock", {31'd0, locked}, 32'd1);

    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk("arst_locked", {31'd0, locked}, 32'd0);
    chk("arst_err_period", {31'd0, err_period}, 32'd0);
    chk("arst_err_duty", {31'd0, err_duty}, 32'd0);
    chk("arst_period_last", {24'd0, period_last}, 32'd0);
    chk("arst_rise_pulse", {31'd0, rise_pulse}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0);
    chk("post_arst_locked", {31'd0, locked}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
